// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and stream constants for the program loader.
package prog_loader_pkg;
  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_CSUM = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } state_t;
  localparam int BYTES_PER_WORD = 2;
  // A length byte of zero stands for a full memory of 2^addr_w words.
  function automatic logic [16:0] decode_len(input logic [7:0] b, input int addr_w);
    return (b == 8'd0) ? (17'd1 << addr_w) : {9'd0, b};
  endfunction
endpackage

// File: rtl/prog_loader.sv
// prog_loader: assembles a host byte stream into instruction words, writes them, and checks a trailing XOR checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [WORD_W-1:0] instr_data,
  output logic              instr_wenable,
  output logic              done,
  output logic              err
);
  state_t state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, idx_q, idx_d;
  logic [7:0]        hi_q, hi_d, csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              wen_q;
  logic              acc, ld_len, ld_hi, ld_lo, last;
  always_ff @(posedge clk) begin
    state_q <= reset ? S_HOLD : state_d;
    wen_q   <= reset ? 1'b1 : (state_d != S_RUN);
    cnt_q   <= reset ? '0 : cnt_d;
    idx_q   <= reset ? '0 : idx_d;
    hi_q    <= reset ? '0 : hi_d;
    csum_q  <= reset ? '0 : csum_d;
    addr_q  <= reset ? '0 : addr_d;
    data_q  <= reset ? '0 : data_d;
  end
  assign acc    = byte_valid && byte_ready;
  assign ld_len = acc && state_q == S_LEN;
  assign ld_hi  = acc && state_q == S_HI;
  assign ld_lo  = acc && state_q == S_LO;
  assign last   = idx_q == cnt_q - 1'b1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD, S_RUN, S_ERR: state_d = start ? S_LEN : state_q;
      S_LEN:                state_d = acc ? S_HI : state_q;
      S_HI:                 state_d = acc ? S_LO : state_q;
      S_LO:                 state_d = acc ? (last ? S_CSUM : S_HI) : state_q;
      S_CSUM:               state_d = acc ? (((csum_q ^ byte_in) == 8'd0) ? S_RUN : S_ERR) : state_q;
      default:              state_d = S_HOLD;
    endcase
  end
  always_comb begin
    cnt_d  = ld_len ? (ADDR_W+1)'(decode_len(byte_in, ADDR_W)) : cnt_q;
    idx_d  = ld_len ? '0 : ld_lo ? idx_q + 1'b1 : idx_q;
    hi_d   = ld_hi ? byte_in : hi_q;
    csum_d = ld_len ? byte_in : (ld_hi || ld_lo) ? csum_q ^ byte_in : csum_q;
    addr_d = ld_lo ? idx_q[ADDR_W-1:0] : addr_q;
    data_d = ld_lo ? WORD_W'({hi_q, byte_in}) : data_q;
  end
  always_comb begin
    byte_ready    = state_q inside {S_LEN, S_HI, S_LO, S_CSUM};
    done          = state_q == S_RUN;
    err           = state_q == S_ERR;
    instr_wenable = wen_q;
    instr_addr    = addr_q;
    instr_data    = data_q;
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed scenario bench for the program loader with a simple instruction-memory model.
module tb_prog_loader;
  logic        clk, reset, start, byte_valid, byte_ready;
  logic [7:0]  byte_in, instr_addr;
  logic [15:0] instr_data;
  logic        instr_wenable, done, err;
  logic [15:0] mem [256];
  int          acc_cnt = 0;
  int          checks = 0, errors = 0;

  prog_loader #(.ADDR_W(8), .WORD_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .instr_addr(instr_addr), .instr_data(instr_data),
    .instr_wenable(instr_wenable), .done(done), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (instr_wenable === 1'b1) mem[instr_addr] <= instr_data;
    if (byte_valid && byte_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in = b;
    byte_valid = 1;
    while (byte_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_timeout: byte_ready=%b want 1 for byte %h", byte_ready, b);
    end
    tick();
    byte_valid = 0;
  endtask

  task automatic send_good_stream();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h42);
  endtask

  task automatic test_reset();
    reset = 1; start = 0; byte_valid = 0; byte_in = 0;
    repeat (2) tick();
    reset = 0;
    for (int r = 0; r < 2; r++) begin
      repeat (r == 0 ? 1 : 10) tick();
      checks++;
      if ({instr_wenable, byte_ready, done, err} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_flags: wen/rdy/done/err=%b want 1000", {instr_wenable, byte_ready, done, err});
      end
      checks++;
      if (instr_addr !== 8'h00 || instr_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_bus: addr=%h data=%h want 00 0000", instr_addr, instr_data);
      end
    end
  endtask

  task automatic test_good_load();
    pulse_start();
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL len_ready: byte_ready=%b want 1", byte_ready);
    end
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    checks++;
    if (instr_addr !== 8'h00 || instr_data !== 16'h1234) begin
      errors++;
      $display("FAIL word0: addr=%h data=%h want 00 1234", instr_addr, instr_data);
    end
    send_byte(8'hAB); send_byte(8'hCD);
    checks++;
    if (instr_addr !== 8'h01 || instr_data !== 16'hABCD) begin
      errors++;
      $display("FAIL word1: addr=%h data=%h want 01 abcd", instr_addr, instr_data);
    end
    checks++;
    if (done !== 1'b0 || instr_wenable !== 1'b1) begin
      errors++;
      $display("FAIL pre_csum: done=%b wen=%b want 0 1", done, instr_wenable);
    end
    send_byte(8'h42);
    checks++;
    if (done !== 1'b1 || instr_wenable !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL good_run: done=%b wen=%b err=%b want 1 0 0", done, instr_wenable, err);
    end
    checks++;
    if (mem[0] !== 16'h1234 || mem[1] !== 16'hABCD) begin
      errors++;
      $display("FAIL good_mem: mem0=%h mem1=%h want 1234 abcd", mem[0], mem[1]);
    end
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h43);
    checks++;
    if (err !== 1'b1 || instr_wenable !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum: err=%b wen=%b done=%b want 1 1 0", err, instr_wenable, done);
    end
    tick();
    checks++;
    if (err !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_hold: err=%b rdy=%b want 1 0", err, byte_ready);
    end
    pulse_start();
    send_good_stream();
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || instr_wenable !== 1'b0) begin
      errors++;
      $display("FAIL err_reload: done=%b err=%b wen=%b want 1 0 0", done, err, instr_wenable);
    end
  endtask

  task automatic test_full_load();
    int base;
    logic [7:0] k;
    pulse_start();
    base = acc_cnt;
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      k = 8'(i);
      repeat ($urandom_range(0, 2)) tick();
      send_byte(k);
      repeat ($urandom_range(0, 1)) tick();
      send_byte(~k);
    end
    send_byte(8'h00);
    checks++;
    if (done !== 1'b1 || instr_wenable !== 1'b0) begin
      errors++;
      $display("FAIL full_run: done=%b wen=%b want 1 0", done, instr_wenable);
    end
    checks++;
    if (acc_cnt - base !== 514) begin
      errors++;
      $display("FAIL full_accepts: got %0d want 514", acc_cnt - base);
    end
    checks++;
    if (instr_addr !== 8'hFF || instr_data !== 16'hFF00) begin
      errors++;
      $display("FAIL full_last: addr=%h data=%h want ff ff00", instr_addr, instr_data);
    end
    for (int i = 0; i < 256; i++) begin
      k = 8'(i);
      checks++;
      if (mem[i] !== {k, ~k}) begin
        errors++;
        $display("FAIL full_mem[%0d]: got %h want %h", i, mem[i], {k, ~k});
      end
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h33);
    send_byte(8'h44);
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if ({instr_wenable, byte_ready, done, err} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset_flags: wen/rdy/done/err=%b want 1000", {instr_wenable, byte_ready, done, err});
    end
    checks++;
    if (instr_addr !== 8'h00 || instr_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_bus: addr=%h data=%h want 00 0000", instr_addr, instr_data);
    end
    pulse_start();
    send_good_stream();
    checks++;
    if (done !== 1'b1 || mem[0] !== 16'h1234 || mem[1] !== 16'hABCD) begin
      errors++;
      $display("FAIL mid_reload: done=%b mem0=%h mem1=%h want 1 1234 abcd", done, mem[0], mem[1]);
    end
  endtask

  task automatic test_start_in_run();
    int base;
    base = acc_cnt;
    start = 1;
    byte_valid = 1;
    byte_in = 8'h02;
    #1;
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_ready: byte_ready=%b want 0", byte_ready);
    end
    tick();
    start = 0;
    byte_valid = 0;
    checks++;
    if (instr_wenable !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_restart: wen=%b done=%b rdy=%b want 1 0 1", instr_wenable, done, byte_ready);
    end
    checks++;
    if (acc_cnt !== base) begin
      errors++;
      $display("FAIL run_no_consume: accepts=%0d want %0d", acc_cnt - base, 0);
    end
    send_good_stream();
    checks++;
    if (done !== 1'b1 || instr_wenable !== 1'b0) begin
      errors++;
      $display("FAIL run_reload: done=%b wen=%b want 1 0", done, instr_wenable);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_full_load();
    test_reset_mid_load();
    test_start_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
